// File: rtl/prog_ram.sv
// Program/data RAM: DEPTH x DW array with a post-reset INIT_VAL sweep, a RUN-mode CPU port and a handshaked PROG loader.
// Latency: CPU read data appears on RAM_OUT one edge after RD_EN; PROG beats are written on the accepting edge.
// Backpressure: READY is low during INIT and PROG; PROG_READY follows PROG_EN while in PROG, otherwise 0.
//
// Ports:
//   CLK, CLR_N              clock, synchronous active-low reset
//   Ain, Din, WE, RD_EN     CPU address / write data / write enable / read enable (RUN only)
//   RAM_OUT, READY          registered read data, high only in RUN
//   PROG_EN, PROG_VALID,    programming request/hold, beat valid, beat data
//   PROG_DATA
//   PROG_READY, PROG_DONE,  beat acceptable, one-cycle pulse on PROG exit,
//   PROG_COUNT              words accepted in last/current session (saturates at DEPTH)
module prog_ram #(
    parameter int             DW       = 8,
    parameter int             AW       = 4,
    parameter logic [DW-1:0]  INIT_VAL = '0
) (
    input  logic          CLK,
    input  logic          CLR_N,
    input  logic [AW-1:0] Ain,
    input  logic [DW-1:0] Din,
    input  logic          WE,
    input  logic          RD_EN,
    output logic [DW-1:0] RAM_OUT,
    output logic          READY,
    input  logic          PROG_EN,
    input  logic          PROG_VALID,
    input  logic [DW-1:0] PROG_DATA,
    output logic          PROG_READY,
    output logic          PROG_DONE,
    output logic [AW:0]   PROG_COUNT
);
    localparam int          DEPTH    = 2 ** AW;
    localparam logic [AW:0] CNT_FULL = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PROG = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          done_q, done_d;
    logic [DW-1:0] ram_out_q;

    logic [DW-1:0] mem_q [DEPTH];

    // Single shared write port: sweep, CPU write and PROG beat are mutually
    // exclusive by state, so one address/data mux feeds the array.
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdat;
    logic          rd_fire;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        count_d  = count_q;
        done_d   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = cnt_q;
        mem_wdat = INIT_VAL;
        rd_fire  = 1'b0;

        case (state_q)
            ST_INIT: begin
                mem_we   = 1'b1;
                mem_addr = cnt_q;
                mem_wdat = INIT_VAL;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == {AW{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Entering PROG takes priority; the CPU strobes of that cycle are dropped.
                if (PROG_EN) begin
                    state_d = ST_PROG;
                    ptr_d   = Ain;
                    count_d = '0;
                end else begin
                    rd_fire = RD_EN;
                    if (WE) begin
                        mem_we   = 1'b1;
                        mem_addr = Ain;
                        mem_wdat = Din;
                    end
                end
            end
            ST_PROG: begin
                if (!PROG_EN) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end else if (PROG_VALID) begin
                    mem_we   = 1'b1;
                    mem_addr = ptr_q;
                    mem_wdat = PROG_DATA;
                    ptr_d    = ptr_q + 1'b1;
                    if (count_q != CNT_FULL) begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Read register sees the pre-write array contents, giving read-before-write
    // on a same-address WE+RD_EN cycle.
    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            ram_out_q <= '0;
        end else if (rd_fire) begin
            ram_out_q <= mem_q[Ain];
        end
    end

    // Array has no reset; a reset cycle simply suppresses the write.
    always_ff @(posedge CLK) begin
        if (CLR_N && mem_we) begin
            mem_q[mem_addr] <= mem_wdat;
        end
    end

    assign RAM_OUT    = ram_out_q;
    assign READY      = (state_q == ST_RUN);
    assign PROG_READY = (state_q == ST_PROG) && PROG_EN;
    assign PROG_DONE  = done_q;
    assign PROG_COUNT = count_q;

endmodule
